// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared types for the 4-bit ALU and its writeback stage.
//   - opcode_t   : ALU operation encoding
//   - wb_entry_t : one buffered writeback entry {result, dest, err}
//   - DATA_W_DEFAULT / REG_W_DEFAULT : widths the entry struct is built from.
//     Modules exposing DATA_W/REG_W parameters default to these values and
//     must be instantiated with matching widths.
//   - opcode_updates_v() : which opcodes own the overflow flag
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W_DEFAULT = 4;
  localparam int REG_W_DEFAULT  = 3;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NAND = 2'b10,
    OP_XOR  = 2'b11
  } opcode_t;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] result;
    logic [REG_W_DEFAULT-1:0]  dest;
    logic                      err;
  } wb_entry_t;

  // Only arithmetic operations can overflow, so only they write V. Logic
  // operations leave the previous V in place.
  function automatic logic opcode_updates_v(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// -----------------------------------------------------------------------------
// alu_wb_fifo
//   In-order DEPTH-entry FIFO of wb_entry_t with valid/ready on both sides.
//   No bypass: an entry written in cycle T is visible at out_entry in T+1.
//   in_ready depends only on the registered count (no out_ready through-path),
//   so a pop on a full FIFO does not admit a push in the same cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   write handshake
//   in_entry              entry to write
//   out_valid / out_ready read handshake
//   out_entry             head entry (zero while empty)
// -----------------------------------------------------------------------------
module alu_wb_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2            // power of two, >= 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  output logic      in_ready,
  input  wb_entry_t in_entry,
  output logic      out_valid,
  input  logic      out_ready,
  output wb_entry_t out_entry
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  wb_entry_t        mem [DEPTH];

  logic push;
  logic pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid  & in_ready;
  assign pop       = out_valid & out_ready;

  // Pointers are exactly log2(DEPTH) bits, so incrementing wraps modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are unobservable until
  // written because out_entry is masked by out_valid, and leaving it unreset
  // lets it map onto plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  // Masking keeps the outputs at zero after reset and while empty. While a
  // head entry waits for out_ready, rd_ptr and that slot are both frozen
  // (a push can only target a different slot), so the outputs hold stable.
  assign out_entry = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/alu_wb_stage.sv
// -----------------------------------------------------------------------------
// alu_wb_stage
//   Writeback stage behind the 4-bit ALU. Accepts {result, err, opcode, dest}
//   via valid/ready, buffers entries in an in-order FIFO for the register-file
//   write port, and maintains the architectural Z/N/V flags from accepted
//   results (registered, visible the cycle after the push).
//
//   Optional build macro ALU_WB_ERRCNT_EN adds err_cnt: a saturating count of
//   accepted results carrying err=1.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   in_valid, in_ready                  upstream handshake
//   in_result, in_err, in_opcode, in_dest  ALU result fields
//   out_valid, out_ready                writeback handshake
//   out_result, out_dest, out_err       head entry fields
//   flag_z, flag_n, flag_v              condition flags
//   err_cnt  [7:0]                      (ALU_WB_ERRCNT_EN only) overflow count
// -----------------------------------------------------------------------------
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,  // must match wb_entry_t.result
  parameter int REG_W  = REG_W_DEFAULT,   // must match wb_entry_t.dest
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_err,
  input  logic [1:0]        in_opcode,
  input  logic [REG_W-1:0]  in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_dest,
  output logic              out_err,
  output logic              flag_z,
  output logic              flag_n,
`ifdef ALU_WB_ERRCNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              flag_v
);

  wb_entry_t in_entry;
  wb_entry_t out_entry;
  opcode_t   op;
  logic      push;

  assign in_entry = '{result: in_result, dest: in_dest, err: in_err};
  assign op       = opcode_t'(in_opcode);
  assign push     = in_valid & in_ready;

  alu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_entry (out_entry)
  );

  assign out_result = out_entry.result;
  assign out_dest   = out_entry.dest;
  assign out_err    = out_entry.err;

  // Flags follow accepted results in program order, independent of when the
  // writeback side drains the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (push) begin
      flag_z <= (in_result == '0);
      flag_n <= in_result[DATA_W-1];
      if (opcode_updates_v(op)) flag_v <= in_err;
    end
  end

`ifdef ALU_WB_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (push && in_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
